// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous, single-cycle-read memory port between
// requester 0 (accelerator) and requester 1 (UART controller).
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   req0/1, we0/1       access request and write-enable (0 = read) per requester
//   addr0/1, wdata0/1   word address and write data per requester
//   lock0/1             keep ownership of the port after the current access
//   gnt0/1              access accepted this cycle (combinational from req)
//   rvalid0/1           rdata holds this requester's read result
//   rdata               shared read data, straight from mem_dr
//   mem_en, mem_we      memory port enable / write enable
//   mem_addr, mem_dw    memory port address / write data
//   mem_dr              memory read data, valid the cycle after an enabled read
//
// Arbitration: in IDLE a lone request is granted; on contention the
// requester not recorded in 'last' wins. A grant with lock set moves to
// LOCKn, where only requester n can be granted, until lockn is seen low.

module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  lock0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic                  lock1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_dw,
  input  logic [DATA_WIDTH-1:0] mem_dr
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOCK0 = 2'd1;
  localparam logic [1:0] LOCK1 = 2'd2;

  logic [1:0] state, state_nxt;
  logic       last;      // index of the most recently granted requester
  logic [1:0] rvalid_q;  // one-cycle read-return flags, bit n = requester n
  logic [1:0] req, lock, we, gnt;

  assign req  = {req1, req0};
  assign lock = {lock1, lock0};
  assign we   = {we1, we0};

  // Grant decode. Reset forces no grant so nothing reaches the memory.
  always_comb begin
    gnt = 2'b00;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (req[0] && req[1]) gnt = last ? 2'b01 : 2'b10;
          else                  gnt = req;
        end
        LOCK0:   gnt = {1'b0, req[0]};
        LOCK1:   gnt = {req[1], 1'b0};
        default: gnt = 2'b00;
      endcase
    end
  end

  // Lock entry needs an actual grant; lock exit happens on lockn=0
  // regardless of whether the owner is requesting that cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (gnt[0] && lock[0])      state_nxt = LOCK0;
        else if (gnt[1] && lock[1]) state_nxt = LOCK1;
      end
      LOCK0:   if (!lock[0]) state_nxt = IDLE;
      LOCK1:   if (!lock[1]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last     <= 1'b1;  // requester 0 wins the first contention
      rvalid_q <= 2'b00;
    end else begin
      state    <= state_nxt;
      if (|gnt) last <= gnt[1];
      rvalid_q <= gnt & ~we;
    end
  end

  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];

  // Gating with reset kills a read return still in flight when reset hits.
  assign rvalid0 = rvalid_q[0] & ~reset;
  assign rvalid1 = rvalid_q[1] & ~reset;
  assign rdata   = mem_dr;

  // Memory port mux; all-zero when nobody is granted.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_dw   = '0;
    if (gnt[0]) begin
      mem_we   = we0;
      mem_addr = addr0;
      mem_dw   = wdata0;
    end else if (gnt[1]) begin
      mem_we   = we1;
      mem_addr = addr1;
      mem_dw   = wdata1;
    end
  end

  assign mem_en = gnt[0] | gnt[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs change 1 time unit after a rising
// edge; outputs are sampled 1 unit later, well away from the next edge.

module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, lock0, req1, we1, lock1;
  logic [15:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we;
  logic [31:0] rdata, mem_dw, mem_dr;
  logic [15:0] mem_addr;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_dw(mem_dw), .mem_dr(mem_dr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance to 1 unit past the next rising edge, then let combinational settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b1; we0 = 1'b1; lock0 = 1'b1; addr0 = 16'h1111; wdata0 = 32'h1;
    req1 = 1'b1; we1 = 1'b1; lock1 = 1'b1; addr1 = 16'h2222; wdata1 = 32'h2;
    mem_dr = 32'h0;

    // reset holds everything quiet even with both requesting writes
    tick(); tick(); #1;
    chk("rst_gnt",    32'({gnt1, gnt0}), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_rvalid", 32'({rvalid1, rvalid0}), 32'h0);

    reset = 1'b0;
    req0 = 1'b0; we0 = 1'b0; lock0 = 1'b0;
    req1 = 1'b0; we1 = 1'b0; lock1 = 1'b0;

    // idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("idle_quiet", 32'({gnt1, gnt0, mem_en, mem_we, rvalid1, rvalid0}), 32'h0);
      chk("idle_addr",  32'(mem_addr), 32'h0);
      tick();
    end

    // single read by requester 0
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
    #1;
    chk("rd0_gnt",   32'({gnt1, gnt0}), 32'h1);
    chk("rd0_en_we", 32'({mem_en, mem_we}), 32'h2);
    chk("rd0_addr",  32'(mem_addr), 32'h0010);
    tick();
    req0 = 1'b0; mem_dr = 32'hDEADBEEF;
    #1;
    chk("rd0_rvalid", 32'({rvalid1, rvalid0}), 32'h1);
    chk("rd0_rdata",  rdata, 32'hDEADBEEF);
    tick();
    chk("rd0_rvalid_once", 32'({rvalid1, rvalid0}), 32'h0);

    // single write by requester 0
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0004; wdata0 = 32'h12345678;
    #1;
    chk("wr0_gnt",   32'({gnt1, gnt0}), 32'h1);
    chk("wr0_en_we", 32'({mem_en, mem_we}), 32'h3);
    chk("wr0_addr",  32'(mem_addr), 32'h0004);
    chk("wr0_dw",    mem_dw, 32'h12345678);
    tick();
    req0 = 1'b0; we0 = 1'b0;
    #1;
    chk("wr0_no_rvalid", 32'({rvalid1, rvalid0}), 32'h0);
    tick();

    // fresh reset, then both read every cycle: 0,1,0,1,0,1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0100;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0200;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_gnt",  32'({gnt1, gnt0}), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("rr_addr", 32'(mem_addr), (k % 2 == 0) ? 32'h0100 : 32'h0200);
      chk("rr_rvalid", 32'({rvalid1, rvalid0}),
          (k == 0) ? 32'h0 : ((k % 2 == 1) ? 32'h1 : 32'h2));
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    #1;
    chk("rr_last_rvalid1", 32'({rvalid1, rvalid0}), 32'h2);
    tick();

    // lone read by 0 so that requester 1 wins the following contention
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0020;
    #1;
    chk("pre_lock_gnt", 32'({gnt1, gnt0}), 32'h1);
    tick();

    // requester 1 locked write for 3 grants while 0 keeps requesting
    req1 = 1'b1; we1 = 1'b1; lock1 = 1'b1; addr1 = 16'h0030; wdata1 = 32'hA5A5A5A5;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) lock1 = 1'b0;
      #1;
      chk("lk1_gnt",   32'({gnt1, gnt0}), 32'h2);
      chk("lk1_en_we", 32'({mem_en, mem_we}), 32'h3);
      chk("lk1_addr",  32'(mem_addr), 32'h0030);
      chk("lk1_dw",    mem_dw, 32'hA5A5A5A5);
      chk("lk1_rvalid1", 32'(rvalid1), 32'h0);
      tick();
    end
    req1 = 1'b0; we1 = 1'b0;
    #1;
    chk("lk1_release_gnt0", 32'({gnt1, gnt0}), 32'h1);
    chk("lk1_no_rvalid1",   32'(rvalid1), 32'h0);
    tick();

    // requester 0 takes a locked read; requester 1 must be shut out
    req0 = 1'b1; we0 = 1'b0; lock0 = 1'b1; addr0 = 16'h0040;
    #1;
    chk("lk0_enter_gnt", 32'({gnt1, gnt0}), 32'h1);
    tick();
    req1 = 1'b1; we1 = 1'b0;
    #1;
    chk("lk0_exclusive", 32'({gnt1, gnt0}), 32'h1);
    tick();
    // reset while locked, with a read granted last cycle
    reset = 1'b1;
    #1;
    chk("lk0_rst_rvalid", 32'({rvalid1, rvalid0}), 32'h0);
    chk("lk0_rst_gnt",    32'({gnt1, gnt0, mem_en, mem_we}), 32'h0);
    tick();
    reset = 1'b0; lock0 = 1'b0;
    #1;
    chk("post_rst_rvalid", 32'({rvalid1, rvalid0}), 32'h0);
    chk("post_rst_gnt0",   32'({gnt1, gnt0}), 32'h1);
    tick();
    // back in IDLE: contention now goes to requester 1
    #1;
    chk("post_rst_rr_gnt1", 32'({gnt1, gnt0}), 32'h2);
    tick();
    req0 = 1'b0; req1 = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, memory word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, memory word width.
REQ-003 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have, for n in {0,1}: reqn  input  1  access request for the current cycle.
REQ-006 SHALL have wen  input  1  write when granted (0 = read).
REQ-007 SHALL have addrn  input  ADDR_WIDTH  word address.
REQ-008 SHALL have wdatan  input  DATA_WIDTH  write data.
REQ-009 SHALL have lockn  input  1  keep ownership after the current access.
REQ-010 SHALL have gntn  output  1  access accepted this cycle.
REQ-011 SHALL have rvalidn  output  1  rdata holds this requester's read result.
REQ-012 SHALL have rdata  output  DATA_WIDTH  shared read data, equal to mem_dr.
REQ-013 SHALL have mem_en, mem_we  output  1  memory port enable and write enable.
REQ-014 SHALL have mem_addr  output  ADDR_WIDTH  and mem_dw  output  DATA_WIDTH  memory port address and write data.
REQ-015 SHALL have mem_dr  input  DATA_WIDTH  memory read data, valid one cycle after the enabled read.

Function
REQ-016 SHALL share one synchronous single-cycle-read memory port between requester 0 (accelerator) and requester 1 (UART controller).
REQ-017 SHALL implement FSM states IDLE, LOCK0 and LOCK1.
REQ-018 SHALL compute gntn combinationally in the same cycle as reqn; at most one gnt is high per cycle.
REQ-019 In IDLE, a single active request SHALL be granted.
REQ-020 In IDLE with both requesting, SHALL grant the requester not recorded in register last (round-robin).
REQ-021 SHALL load last with the granted index on every grant.
REQ-022 When gntn=1 and lockn=1, SHALL transition to LOCKn at the next edge.
REQ-023 In LOCKn, SHALL grant only requester n (when reqn=1); the other requester is never granted.
REQ-024 In LOCKn, SHALL return to IDLE at the edge where lockn=0, whether or not reqn is high in that cycle.
REQ-025 SHALL drive mem_en = gnt0|gnt1.
REQ-026 SHALL drive mem_we, mem_addr and mem_dw from the granted requester's we/addr/wdata.
REQ-027 With no grant, SHALL drive mem_we=0, mem_addr=0 and mem_dw=0.
REQ-028 SHALL assert rvalidn for exactly one cycle, the cycle after a granted read (gntn=1, wen=0).
REQ-029 SHALL never assert rvalidn after a granted write.
REQ-030 SHALL sustain back-to-back grants every cycle with no idle bubble; rvalid of access k SHALL coincide with the grant of access k+1.
REQ-031 An ungranted requester SHALL hold req, we, addr and wdata stable until granted; the arbiter keeps no request queue.

Reset
REQ-032 While reset=1, SHALL hold gnt0=gnt1=0, mem_en=0 and mem_we=0 regardless of inputs.
REQ-033 At the first edge with reset=1, SHALL set state to IDLE, last to 1 (requester 0 wins the first contention) and rvalid0=rvalid1=0.
REQ-034 Reset asserted mid-lock or mid-read SHALL abandon the lock and suppress any pending rvalid.

Verification
REQ-035 Read by requester 0 only (req0=1, we0=0, addr0=0x0010) with mem_dr returning 0xDEADBEEF -> gnt0=1 and mem_addr=0x0010 in the same cycle; rvalid0=1 and rdata=0xDEADBEEF the next cycle.
REQ-036 Both requesting reads continuously from reset -> grants alternate 0,1,0,1; rvalid0 and rvalid1 each follow their grant by exactly one cycle.
REQ-037 Requester 1 write with lock1=1 for 3 cycles, req0=1 throughout -> gnt1 high 3 cycles, mem_we=1, gnt0=0; gnt0=1 on the cycle after lock1 falls.
REQ-038 Write by requester 0 (addr0=0x0004, wdata0=0x12345678) -> mem_en=mem_we=1 with those values in the grant cycle; rvalid0 stays 0.
REQ-039 Reset pulsed while in LOCK0 with a read granted the previous cycle -> rvalid0=0 in the reset cycle; state IDLE afterwards; next contention grants requester 0.
REQ-040 No requests for 10 cycles -> mem_en=0, mem_we=0, mem_addr=0, gnt0=gnt1=0 and no rvalid throughout.
